mem_grant_sequencer: RTL and testbench
======================================

Name: mem_grant_sequencer

Overview:
Downstream stage of the 3-requestor round-robin memory arbiter. Consumes the arbiter's one-hot grant and latches the granted requestor's command (address, write data, write enable). Runs a single memory access over a req/ack memory port with a timeout, then returns a one-cycle done/err pulse and read data to that requestor. Only one access is in flight at a time. The busy output lets upstream logic mask requests while an access is running.

Parameters:
ADDR_W, 8, memory address width per requestor
DATA_W, 16, memory data width
TIMEOUT, 15, max cycles mem_req stays high without mem_ack before abort (legal range 1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
grant  in  3  one-hot grant from arbiter; bit i selects requestor i
req_addr  in  3*ADDR_W  requestor i address at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  3*DATA_W  requestor i write data at bits [i*DATA_W +: DATA_W]
req_we  in  3  requestor i write enable (1=write, 0=read)
busy  out  1  high while not IDLE
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  latched write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_ack  in  1  memory acknowledge, sampled only while mem_req=1
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack=1
done  out  3  one-cycle completion pulse to the owning requestor
err  out  3  one-cycle timeout pulse to the owning requestor
rdata  out  DATA_W  last successfully read data
seq_state  out  2  debug: 00 IDLE, 01 ACCESS, 10 RESP

Behaviour:
- Reset (asynchronous, active-high; clock clk): all outputs and internal registers go to 0 immediately. State = IDLE. An in-flight access is abandoned: no done or err pulse is issued.
- All outputs are registered.
- IDLE:
  - grant exactly one-hot: latch the owner index and that requestor's addr, wdata and we. Next state ACCESS; mem_req=1, wait counter=0.
  - grant=000 or multi-hot: ignored, stay IDLE, nothing latched.
- ACCESS:
  - mem_ack=1 at an edge: mem_req->0. If this is a read, rdata<=mem_rdata. Next state RESP with done[owner]=1.
  - No ack and counter==TIMEOUT-1: mem_req->0, rdata unchanged. Next state RESP with done[owner]=1 and err[owner]=1.
  - Otherwise: counter increments; mem_req, mem_addr, mem_wdata and mem_we stay stable.
  - Ack and timeout at the same edge: ack wins, no err.
- RESP: done and err are high for exactly this one cycle, then IDLE. Any grant sampled in RESP is ignored.
- Grants while busy=1 (ACCESS or RESP) are dropped. Upstream must gate its requests with busy.
- Minimum latency: grant sampled at edge E0, mem_req high from E0, ack sampled at E1, done high E1..E2, IDLE at E2. Next grant is accepted at edge E2.
- Timeout case: mem_req is high for exactly TIMEOUT cycles.
- Writes never modify rdata. A timed-out read never modifies rdata.
- mem_addr, mem_wdata and mem_we hold their last values outside ACCESS (reset to 0).
- seq_state=11 is unreachable; if entered, the next state is IDLE with all pulses low.
- Counter width is 8 bits and it does not wrap within the legal TIMEOUT range.

Test Plan:
- Read from req1: grant=010, req_addr[1]=8'h3C, req_we=000; memory acks on the first ACCESS cycle with rdata 16'hBEEF -> mem_addr=3C, mem_we=0; done=010 for one cycle two edges after grant; rdata=BEEF; err=000.
- Write from req2: grant=100, addr 8'h05, wdata 16'h1234, we[2]=1; ack after 3 cycles -> mem_req high 4 cycles, mem_wdata=1234, mem_we=1; done=100; rdata unchanged.
- Timeout: TIMEOUT=15, read from req0, mem_ack held 0 -> mem_req high exactly 15 cycles, then done=001 and err=001 in the same cycle; rdata unchanged; IDLE after.
- Ack exactly on the timeout edge (cycle 15) -> done=001, err=000, rdata updated.
- Illegal and busy grants: grant=011 in IDLE -> stays IDLE, busy=0. grant=001 arriving during ACCESS of req1 -> ignored, only done=010 is produced.
- Reset asserted mid-ACCESS -> mem_req, busy and seq_state go to 0 asynchronously; no done pulse; after release, a new grant=001 completes normally.

Source files
------------

// File: rtl/mem_grant_sequencer.sv
// mem_grant_sequencer
// Takes the arbiter's one-hot grant and latches the owner's command. Runs one
// memory access on a req/ack port with a timeout. Then returns a one-cycle
// done/err pulse and the read data to that owner. Only one access is in
// flight at a time.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   grant[2:0]         one-hot grant from the arbiter
//   req_addr/wdata/we  packed per-requestor command fields (slot i = requestor i)
//   busy               high while the sequencer is not IDLE
//   mem_req/we/addr/wdata  memory request port, held stable during an access
//   mem_ack, mem_rdata memory acknowledge and read data
//   done[2:0], err[2:0] one-cycle completion / timeout pulses to the owner
//   rdata              last successfully read data
//   seq_state[1:0]     debug: 00 IDLE, 01 ACCESS, 10 RESP
module mem_grant_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          grant,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  input  logic [2:0]          req_we,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          done,
  output logic [2:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          seq_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10,
    BAD    = 2'b11
  } state_t;

  // Last counter value before the access is aborted. The counter starts at 0
  // on the grant edge, so mem_req ends up high for exactly TIMEOUT cycles.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [1:0]  owner_reg;
  logic [7:0]  wait_cnt_reg;

  // Unpacked views of the per-requestor command slots.
  logic [ADDR_W-1:0] addr_arr  [3];
  logic [DATA_W-1:0] wdata_arr [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Only an exactly one-hot grant starts an access. Zero and multi-hot grants
  // are ignored.
  logic       grant_valid;
  logic [1:0] grant_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    case (grant)
      3'b001: begin grant_valid = 1'b1; grant_idx = 2'd0; end
      3'b010: begin grant_valid = 1'b1; grant_idx = 2'd1; end
      3'b100: begin grant_valid = 1'b1; grant_idx = 2'd2; end
      default: begin grant_valid = 1'b0; grant_idx = 2'd0; end
    endcase
  end

  logic [2:0] owner_onehot;
  assign owner_onehot = 3'(3'b001 << owner_reg);

  assign seq_state = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= 2'd0;
      wait_cnt_reg <= 8'd0;
      busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 3'b000;
      err          <= 3'b000;
      rdata        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 3'b000;
          err  <= 3'b000;
          if (grant_valid) begin
            owner_reg    <= grant_idx;
            mem_addr     <= addr_arr[grant_idx];
            mem_wdata    <= wdata_arr[grant_idx];
            mem_we       <= req_we[grant_idx];
            mem_req      <= 1'b1;
            busy         <= 1'b1;
            wait_cnt_reg <= 8'd0;
            state_reg    <= ACCESS;
          end
        end

        ACCESS: begin
          // Ack is checked first so an ack on the timeout edge still succeeds.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            done      <= owner_onehot;
            state_reg <= RESP;
          end else if (wait_cnt_reg == LAST_CNT) begin
            mem_req   <= 1'b0;
            done      <= owner_onehot;
            err       <= owner_onehot;
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        RESP: begin
          done      <= 3'b000;
          err       <= 3'b000;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          // Unreachable encoding. Go back to IDLE quietly.
          done      <= 3'b000;
          err       <= 3'b000;
          mem_req   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_grant_sequencer.sv
module tb_mem_grant_sequencer;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic                clk;
  logic                reset;
  logic [2:0]          grant;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          req_we;
  logic                busy;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  logic [2:0]          done;
  logic [2:0]          err;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          seq_state;

  mem_grant_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .grant    (grant),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_we   (req_we),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .seq_state(seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  done;
    logic [2:0]  err;
    logic [15:0] rdata;
  } resp_t;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
  } memop_t;

  resp_t  exp_resp[$];
  memop_t exp_mem[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Response monitor: every cycle with a done/err pulse consumes one expectation.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (done !== 3'b000 || err !== 3'b000) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_resp", {26'd0, done, err}, 32'd0);
        end else begin
          r = exp_resp.pop_front();
          check("resp_done",  {29'd0, done}, {29'd0, r.done});
          check("resp_err",   {29'd0, err},  {29'd0, r.err});
          check("resp_rdata", {16'd0, rdata}, {16'd0, r.rdata});
        end
      end
    end
  end

  // Memory-port monitor: each ack handshake consumes one expected command.
  initial begin
    memop_t m;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem", 32'd1, 32'd0);
        end else begin
          m = exp_mem.pop_front();
          check("mem_addr",  {24'd0, mem_addr},  {24'd0, m.addr});
          check("mem_we",    {31'd0, mem_we},    {31'd0, m.we});
          check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
        end
      end
    end
  end

  // One full access. ack_at = the mem_req cycle (1-based) in which ack is
  // driven. 0 means no ack. noise is a grant driven while the access is in flight.
  task automatic run_access(input int own, input logic [7:0] addr, input logic [15:0] wd,
                            input logic we, input int ack_at, input logic [15:0] ack_data,
                            input logic [2:0] noise, input logic [15:0] exp_rd,
                            input int exp_cycles);
    logic [2:0] oh;
    resp_t r;
    memop_t m;
    int c;
    oh = 3'(3'b001 << own);
    r.done = oh;
    r.err = (ack_at == 0) ? oh : 3'b000;
    r.rdata = exp_rd;
    exp_resp.push_back(r);
    if (ack_at != 0) begin
      m.addr = addr; m.we = we; m.wdata = wd;
      exp_mem.push_back(m);
    end
    @(negedge clk);
    req_addr  = {3{8'hA5}};
    req_wdata = {3{16'h5AA5}};
    req_addr[own*ADDR_W +: ADDR_W]  = addr;
    req_wdata[own*DATA_W +: DATA_W] = wd;
    req_we = we ? oh : ~oh;
    grant  = oh;
    @(negedge clk);
    grant = noise;
    check("busy_in_access", {31'd0, busy}, 32'd1);
    check("state_access", {30'd0, seq_state}, 32'd1);
    c = 0;
    while (mem_req === 1'b1 && c < 300) begin
      c++;
      mem_ack   = (c == ack_at);
      mem_rdata = (c == ack_at) ? ack_data : 16'hDEAD;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    grant   = 3'b000;
    check("mem_req_cycles", c, exp_cycles);
    @(negedge clk);
    check("state_idle_after", {30'd0, seq_state}, 32'd0);
    check("busy_idle_after", {31'd0, busy}, 32'd0);
    check("mem_addr_hold", {24'd0, mem_addr}, {24'd0, addr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    grant     = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 3'b000;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, mem_req, mem_we, done, err, seq_state}, 32'd0);
    check("reset_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Read from req1 with an immediate ack.
    run_access(1, 8'h3C, 16'h0000, 1'b0, 1, 16'hBEEF, 3'b000, 16'hBEEF, 1);
    // Write from req2 with the ack in the fourth cycle. rdata must not change.
    run_access(2, 8'h05, 16'h1234, 1'b1, 4, 16'hFFFF, 3'b000, 16'hBEEF, 4);
    // Timed-out read from req0.
    run_access(0, 8'h7A, 16'h0000, 1'b0, 0, 16'h0000, 3'b000, 16'hBEEF, TIMEOUT);
    // Ack on the timeout edge: ack wins.
    run_access(0, 8'h11, 16'h0000, 1'b0, TIMEOUT, 16'hCAFE, 3'b000, 16'hCAFE, TIMEOUT);
    // Read from req1 while req0 is granted mid-access. The extra grant is dropped.
    run_access(1, 8'h22, 16'h0000, 1'b0, 3, 16'h5A5A, 3'b001, 16'h5A5A, 3);
    // Write from req0. The bus data during the ack must be ignored.
    run_access(0, 8'h66, 16'h9876, 1'b1, 2, 16'hFFFF, 3'b000, 16'h5A5A, 2);

    // Illegal grants in IDLE.
    @(negedge clk);
    grant = 3'b011;
    @(negedge clk);
    check("illegal_011_state", {29'd0, busy, seq_state}, 32'd0);
    grant = 3'b111;
    @(negedge clk);
    check("illegal_111_state", {29'd0, busy, seq_state}, 32'd0);
    check("illegal_mem_req", {31'd0, mem_req}, 32'd0);
    grant = 3'b000;

    // Reset in the middle of an access: no response, outputs drop asynchronously.
    @(negedge clk);
    req_addr[0 +: ADDR_W] = 8'h99;
    req_we = 3'b000;
    grant = 3'b001;
    @(negedge clk);
    grant = 3'b000;
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_state", {30'd0, seq_state}, 32'd0);
    check("async_reset_done", {29'd0, done}, 32'd0);
    check("async_reset_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_access(0, 8'h44, 16'h0000, 1'b0, 2, 16'h0F0F, 3'b000, 16'h0F0F, 2);

    @(negedge clk);
    @(negedge clk);
    check("resp_queue_drained", exp_resp.size(), 32'd0);
    check("mem_queue_drained", exp_mem.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
